multiplicador_seq: RTL

- Parametrised sequential shift-add multiplier. Successor to the fixed 5x5 ROM lookup multiplier.
- Adds unsigned and two's-complement modes, an `iniciar`/`pronto` handshake, and a deterministic latency.
- Serves as the generic multiply unit for the next datapaths, where WIDTH makes a 2^(2*WIDTH) ROM impractical.

---
 rtl/multiplicador_seq_pkg.sv | 26 ++
 rtl/multiplicador_seq_if.sv | 26 ++
 rtl/multiplicador_seq_fd.sv | 79 +++++++
 rtl/multiplicador_seq.sv | 71 +++++++
 4 files changed

// File: rtl/multiplicador_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and a two's-complement magnitude helper usable at any operand width.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_OCIOSO  = 2'b00,
    ST_CALCULA = 2'b01,
    ST_AJUSTE  = 2'b10
  } state_t;

  // Widest operand the magnitude helper handles; callers zero-extend into it.
  localparam int MAX_W = 64;

  // Magnitude of the low w bits of v read as two's complement. |-2^(w-1)|
  // comes back as 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [MAX_W-1:0] abs_tc(input logic [MAX_W-1:0] v,
                                              input int unsigned     w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] neg;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    neg  = (~v) + MAX_W'(1);
    if (v[w-1]) abs_tc = neg & mask;
    else        abs_tc = v & mask;
  endfunction

endpackage

// File: rtl/multiplicador_seq_if.sv
// Request/response bundle between a client and the sequential multiplier.
interface multiplicador_seq_if #(
  parameter int WIDTH = 5
);
  // Handshake: iniciar is honoured only on an edge where ocupado=0; the operands
  // and com_sinal are captured on that same edge and may change afterwards.
  // pronto pulses for one cycle when resultado first shows the new product;
  // resultado then holds until the next completion or reset.
  logic               iniciar;
  logic               com_sinal;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] resultado;
  logic               pronto;
  logic               ocupado;

  modport master (
    output iniciar, com_sinal, a, b,
    input  resultado, pronto, ocupado
  );

  modport slave (
    input  iniciar, com_sinal, a, b,
    output resultado, pronto, ocupado
  );
endinterface

// File: rtl/multiplicador_seq_fd.sv
// Datapath of the shift-add multiplier: operand magnitudes, accumulator,
// iteration counter and the final sign correction into the result register.
module multiplicador_seq_fd
  import mult_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_fix,
  input  logic               i_com_sinal,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_resultado,
  output logic               o_pronto,
  output logic               o_cnt_last
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] r_mag_a;
  logic [WIDTH-1:0] r_mag_b;
  logic [PW-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic [PW-1:0]    r_resultado;
  logic             r_pronto;

  logic [WIDTH-1:0] w_mag_a_in;
  logic [WIDTH-1:0] w_mag_b_in;
  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_acc_neg;

  // Unsigned mode keeps the raw bits; signed mode works on magnitudes and
  // restores the sign once at the end.
  assign w_mag_a_in = i_com_sinal
    ? WIDTH'(abs_tc({{(MAX_W-WIDTH){1'b0}}, i_a}, WIDTH)) : i_a;
  assign w_mag_b_in = i_com_sinal
    ? WIDTH'(abs_tc({{(MAX_W-WIDTH){1'b0}}, i_b}, WIDTH)) : i_b;

  assign w_addend  = {{WIDTH{1'b0}}, r_mag_a} << r_cnt;
  assign w_acc_neg = (~r_acc) + PW'(1);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_mag_a     <= '0;
      r_mag_b     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_resultado <= '0;
      r_pronto    <= 1'b0;
    end else begin
      r_pronto <= i_fix;
      if (i_load) begin
        r_mag_a <= w_mag_a_in;
        r_mag_b <= w_mag_b_in;
        r_neg   <= i_com_sinal & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        r_acc   <= '0;
        r_cnt   <= '0;
      end
      if (i_step) begin
        if (r_mag_b[0]) r_acc <= r_acc + w_addend;
        r_mag_b <= r_mag_b >> 1;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      // A zero accumulator negates to zero, so -0 never shows up as a pattern.
      if (i_fix) r_resultado <= r_neg ? w_acc_neg : r_acc;
    end
  end

  assign o_cnt_last  = (r_cnt == CNT_W'(WIDTH - 1));
  assign o_resultado = r_resultado;
  assign o_pronto    = r_pronto;

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential shift-add multiplier, unsigned or two's complement, fixed latency
// of WIDTH+2 edges from the accepting edge to the end of the pronto pulse.
module multiplicador_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 5,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  multiplicador_seq_if.slave  mult,
  output state_t              o_estado
);

  state_t r_estado;
  state_t w_prox;
  logic   w_load;
  logic   w_step;
  logic   w_fix;
  logic   w_cnt_last;

  always_ff @(posedge clock) begin
    if (!reset) r_estado <= ST_OCIOSO;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    case (r_estado)
      ST_OCIOSO: begin
        if (mult.iniciar) begin
          w_load = 1'b1;
          w_prox = ST_CALCULA;
        end
      end
      ST_CALCULA: begin
        w_step = 1'b1;
        if (w_cnt_last) w_prox = ST_AJUSTE;
      end
      ST_AJUSTE: begin
        w_fix  = 1'b1;
        w_prox = ST_OCIOSO;
      end
      default: w_prox = ST_OCIOSO;
    endcase
  end

  multiplicador_seq_fd #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_fd (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_fix       (w_fix),
    .i_com_sinal (mult.com_sinal),
    .i_a         (mult.a),
    .i_b         (mult.b),
    .o_resultado (mult.resultado),
    .o_pronto    (mult.pronto),
    .o_cnt_last  (w_cnt_last)
  );

  assign mult.ocupado = (r_estado != ST_OCIOSO);
  assign o_estado     = r_estado;

endmodule
